// File: rtl/hmac_sha512_cached.sv
// Single-block HMAC-SHA512 engine with cached ipad/opad midstates.
// A full run is four compressions (IPAD, OPAD, MSG, SUM); a run with key_reuse
// and a valid cache skips IPAD/OPAD. The SHA-512 compression engine
// (one round per clock) is embedded below and shared by all four phases.
// Ports:
//   clk, reset (async active-low)
//   start, key_reuse, msg_len, key, msg : run request and operands, captured on accept
//   busy        : run in progress (DECIDE through the cycle before done)
//   done        : one-cycle pulse, out/err valid
//   err         : msg_len exceeded MSG_MAX_BYTES on the last run
//   cache_valid : mid_i/mid_o hold the midstates of the last non-reused key
//   out         : HMAC result, held until overwritten by a later successful run
module hmac_sha512_cached #(
  parameter int unsigned MSG_MAX_BYTES = 111,
  parameter int unsigned LEN_W         = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       key_reuse,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic [1023:0]              key,
  input  logic [8*MSG_MAX_BYTES-1:0] msg,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       cache_valid,
  output logic [511:0]               out
);

  localparam int unsigned MSG_W = 8 * MSG_MAX_BYTES;
  localparam int unsigned PAD_W = 896;  // bytes 0..111 of a block

  localparam logic [511:0] SHA_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam logic [0:79][63:0] K_TAB = {
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  typedef enum logic [3:0] {
    S_IDLE, S_DECIDE, S_IPAD_0, S_IPAD_R, S_OPAD_0, S_OPAD_R,
    S_MSG_0, S_MSG_R, S_SUM_0, S_SUM_R, S_DONE
  } state_t;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (32'd64 - n));
  endfunction

  state_t               state_q, state_d;
  logic                 accept_c, busy_d, done_d, err_d, cv_d, c_run_c;
  logic [1023:0]        key_q;
  logic [MSG_W-1:0]     msg_q;
  logic [LEN_W-1:0]     len_q;
  logic                 reuse_q;
  logic [511:0]         mid_i_q, mid_o_q, inner_q;
  logic                 len_bad_c;

  // Compression engine state
  logic [7:0][63:0]     v_q, v_n;
  logic [15:0][63:0]    w_q;
  logic [63:0]          w_new_c;
  logic [511:0]         c_ihq, c_oh_q, c_oh_n;
  logic [6:0]           rnd_q;
  logic                 c_done_q;
  logic [1023:0]        c_blk_c, msg_blk_c;
  logic [511:0]         c_ih_c;
  logic [PAD_W-1:0]     msg_pad_c;

  assign len_bad_c = 32'(len_q) > MSG_MAX_BYTES;
  // The engine is held in its load state everywhere except the X_R states
  assign c_run_c = (state_q == S_IPAD_R) || (state_q == S_OPAD_R) ||
                   (state_q == S_MSG_R)  || (state_q == S_SUM_R);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    err_d    = err;
    cv_d     = cache_valid;
    case (state_q)
      S_IDLE: if (start) begin
        accept_c = 1'b1;
        state_d  = S_DECIDE;
      end
      S_DECIDE: begin
        if (len_bad_c) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d = 1'b0;
          if (reuse_q && cache_valid) begin
            state_d = S_MSG_0;
          end else begin
            cv_d    = 1'b0;
            state_d = S_IPAD_0;
          end
        end
      end
      S_IPAD_0: state_d = S_IPAD_R;
      S_IPAD_R: if (c_done_q) state_d = S_OPAD_0;
      S_OPAD_0: state_d = S_OPAD_R;
      S_OPAD_R: if (c_done_q) begin
        cv_d    = 1'b1;
        state_d = S_MSG_0;
      end
      S_MSG_0:  state_d = S_MSG_R;
      S_MSG_R:  if (c_done_q) state_d = S_SUM_0;
      S_SUM_0:  state_d = S_SUM_R;
      S_SUM_R:  if (c_done_q) state_d = S_DONE;
      S_DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = S_DECIDE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // Operand capture, midstate cache and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q       <= '0;
      msg_q       <= '0;
      len_q       <= '0;
      reuse_q     <= 1'b0;
      mid_i_q     <= '0;
      mid_o_q     <= '0;
      inner_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cache_valid <= 1'b0;
      out         <= '0;
    end else begin
      if (accept_c) begin
        key_q   <= key;
        msg_q   <= msg;
        len_q   <= msg_len;
        reuse_q <= key_reuse;
      end
      if (c_done_q) begin
        case (state_q)
          S_IPAD_R: mid_i_q <= c_oh_q;
          S_OPAD_R: mid_o_q <= c_oh_q;
          S_MSG_R:  inner_q <= c_oh_q;
          S_SUM_R:  out     <= c_oh_q;
          default: ;
        endcase
      end
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      cache_valid <= cv_d;
    end
  end

  // Padded message block: data, 0x80 terminator, zeros, bit length (128+L)*8
  always_comb begin
    msg_pad_c = {msg_q, {(PAD_W - MSG_W){1'b0}}};
    msg_blk_c = '0;
    for (int b = 0; b < 112; b++) begin
      if (b < int'(len_q))       msg_blk_c[1023-8*b -: 8] = msg_pad_c[PAD_W-1-8*b -: 8];
      else if (b == int'(len_q)) msg_blk_c[1023-8*b -: 8] = 8'h80;
    end
    msg_blk_c[127:0] = 128'({len_q, 3'b000}) + 128'd1024;
  end

  // Block and chaining-value selection per phase
  always_comb begin
    c_blk_c = '0;
    c_ih_c  = SHA_IV;
    case (state_q)
      S_IPAD_0, S_IPAD_R: c_blk_c = key_q ^ {128{8'h36}};
      S_OPAD_0, S_OPAD_R: c_blk_c = key_q ^ {128{8'h5c}};
      S_MSG_0, S_MSG_R: begin
        c_blk_c = msg_blk_c;
        c_ih_c  = mid_i_q;
      end
      S_SUM_0, S_SUM_R: begin
        c_blk_c = {inner_q, 8'h80, 376'd0, 128'h600};
        c_ih_c  = mid_o_q;
      end
      default: ;
    endcase
  end

  // One SHA-512 round plus the next message-schedule word
  always_comb begin
    logic [63:0] s0, s1, ch, maj, t1, t2;
    s1  = rotr(v_q[4], 14) ^ rotr(v_q[4], 18) ^ rotr(v_q[4], 41);
    ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    t1  = v_q[7] + s1 + ch + K_TAB[rnd_q] + w_q[0];
    s0  = rotr(v_q[0], 28) ^ rotr(v_q[0], 34) ^ rotr(v_q[0], 39);
    maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
    t2  = s0 + maj;
    v_n[0] = t1 + t2;
    v_n[1] = v_q[0];
    v_n[2] = v_q[1];
    v_n[3] = v_q[2];
    v_n[4] = v_q[3] + t1;
    v_n[5] = v_q[4];
    v_n[6] = v_q[5];
    v_n[7] = v_q[6];
    w_new_c = (rotr(w_q[14], 19) ^ rotr(w_q[14], 61) ^ (w_q[14] >> 6)) + w_q[9] +
              (rotr(w_q[1], 1) ^ rotr(w_q[1], 8) ^ (w_q[1] >> 7)) + w_q[0];
    for (int i = 0; i < 8; i++) c_oh_n[511-64*i -: 64] = c_ihq[511-64*i -: 64] + v_n[i];
  end

  // Compression engine: loads while held, then 80 rounds; done is set with the
  // final round so the result is available C=80 cycles after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q      <= '0;
      w_q      <= '0;
      c_ihq    <= '0;
      c_oh_q   <= '0;
      rnd_q    <= '0;
      c_done_q <= 1'b0;
    end else if (!c_run_c) begin
      for (int i = 0; i < 8; i++)  v_q[i] <= c_ih_c[511-64*i -: 64];
      for (int i = 0; i < 16; i++) w_q[i] <= c_blk_c[1023-64*i -: 64];
      c_ihq    <= c_ih_c;
      rnd_q    <= '0;
      c_done_q <= 1'b0;
    end else if (!c_done_q) begin
      v_q <= v_n;
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w_new_c;
      rnd_q   <= rnd_q + 7'd1;
      if (rnd_q == 7'd79) begin
        c_done_q <= 1'b1;
        c_oh_q   <= c_oh_n;
      end
    end
  end

endmodule

// File: tb/tb_hmac_sha512_cached.sv
// Self-checking bench for hmac_sha512_cached: RFC4231 vectors, cache reuse,
// length boundaries, error runs, handshake corner cases and mid-run reset.
module tb_hmac_sha512_cached;

  localparam int unsigned MAXB = 111;
  localparam int C_LAT  = 80;
  localparam int FULL   = 4 * (C_LAT + 2) + 2;
  localparam int CACHED = 2 * (C_LAT + 2) + 2;
  localparam int ERRLAT = 2;

  localparam logic [511:0] TC1_OUT = 512'h87aa7cdea5ef619d4ff0b4241a1d6cb02379f4e2ce4ec2787ad0b30545e17cdedaa833b7d6b8a702038b274eaea3f4e4be9d914eeb61f1702e696c203a126854;
  localparam logic [511:0] TC2_OUT = 512'h164b7a7bfcf819e2e395fbe73b56e0a387bd64222e831fd610270cd7ea2505549758bf75c05a994a6d034f65f8f0e6fdcaeab1a34d4a6b4b636e070a38bce737;

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam logic [63:0] KT [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            key_reuse;
  logic [6:0]      msg_len;
  logic [1023:0]   key;
  logic [887:0]    msg;
  logic            busy, done, err, cache_valid;
  logic [511:0]    out;

  always #5 clk = ~clk;

  hmac_sha512_cached #(.MSG_MAX_BYTES(111), .LEN_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .key_reuse(key_reuse),
    .msg_len(msg_len), .key(key), .msg(msg), .busy(busy), .done(done),
    .err(err), .cache_valid(cache_valid), .out(out));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference SHA-512 compression with a full 80-word schedule
  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] compress(input logic [511:0] hin, input logic [1023:0] blk);
    logic [63:0] w [80];
    logic [63:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[1023-64*t -: 64];
    for (int t = 16; t < 80; t++)
      w[t] = (rr(w[t-2], 19) ^ rr(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7] +
             (rr(w[t-15], 1) ^ rr(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
    a = hin[511:448]; b = hin[447:384]; c = hin[383:320]; d = hin[319:256];
    e = hin[255:192]; f = hin[191:128]; g = hin[127:64];  h = hin[63:0];
    for (int t = 0; t < 80; t++) begin
      t1 = h + (rr(e, 14) ^ rr(e, 18) ^ rr(e, 41)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rr(a, 28) ^ rr(a, 34) ^ rr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[511:448] + a, hin[447:384] + b, hin[383:320] + c, hin[319:256] + d,
            hin[255:192] + e, hin[191:128] + f, hin[127:64] + g, hin[63:0] + h};
  endfunction

  function automatic logic [511:0] hmac_model(input logic [1023:0] k, input logic [887:0] m, input int len);
    logic [511:0]  mi, mo, inner;
    logic [1023:0] blk;
    logic [127:0]  bits;
    mi  = compress(IV, k ^ {128{8'h36}});
    mo  = compress(IV, k ^ {128{8'h5c}});
    blk = '0;
    for (int b = 0; b < len; b++) blk[1023-8*b -: 8] = m[887-8*b -: 8];
    blk[1023-8*len -: 8] = 8'h80;
    bits = 128'((128 + len) * 8);
    blk[127:0] = bits;
    inner = compress(mi, blk);
    return compress(mo, {inner, 8'h80, 376'd0, 128'h600});
  endfunction

  function automatic logic [887:0] rand_msg();
    logic [887:0] m;
    for (int b = 0; b < 111; b++) m[887-8*b -: 8] = 8'($urandom());
    return m;
  endfunction

  // Apply one run; lat counts clock edges from the start cycle to the done cycle
  task automatic do_run(input logic [1023:0] k, input logic [887:0] m, input logic [6:0] l,
                        input logic r, output int lat, output logic cv_mid,
                        output logic busy_ok, output logic pulse_ok);
    @(negedge clk);
    key = k; msg = m; msg_len = l; key_reuse = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key = ~k; msg = ~m; msg_len = 7'd127; key_reuse = ~r;
    lat = 1;
    busy_ok = busy;
    cv_mid = cache_valid;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (lat == 2) cv_mid = cache_valid;
      if (!done && !busy) busy_ok = 1'b0;
    end
    if (busy) busy_ok = 1'b0;
    @(negedge clk);
    pulse_ok = !done;
  endtask

  typedef struct {
    logic [1023:0] k;
    logic [887:0]  m;
    logic [6:0]    len;
    logic          reuse;
    logic [511:0]  exp_out;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [1023:0] k1, k2, ka, kb;
    logic [887:0]  m1, m2, r0, r1, r2, r3;
    logic          cv_m, cv_mid, busy_ok, pulse_ok, exp_cv_mid;
    int            lat;

    k1 = {{20{8'h0b}}, {108{8'h00}}};
    m1 = {"Hi There", {103{8'h00}}};
    k2 = {"Jefe", {124{8'h00}}};
    m2 = {"what do ya want for nothing?", {83{8'h00}}};
    ka = '0;
    kb = '0;
    for (int i = 0; i < 10; i++) ka[1023-32*i -: 32] = $urandom();
    for (int i = 0; i < 32; i++) kb[1023-32*i -: 32] = $urandom();
    r0 = rand_msg(); r1 = rand_msg(); r2 = rand_msg(); r3 = rand_msg();

    vecs[0] = '{k1, m1, 7'd8,   1'b0, TC1_OUT, 1'b0, FULL};
    vecs[1] = '{k2, m2, 7'd28,  1'b0, TC2_OUT, 1'b0, FULL};
    vecs[2] = '{k2, m2, 7'd28,  1'b1, TC2_OUT, 1'b0, CACHED};
    vecs[3] = '{k1, m1, 7'd8,   1'b0, TC1_OUT, 1'b0, FULL};
    vecs[4] = '{ka, r0, 7'd0,   1'b0, hmac_model(ka, r0, 0),   1'b0, FULL};
    vecs[5] = '{ka, r1, 7'd36,  1'b1, hmac_model(ka, r1, 36),  1'b0, CACHED};
    vecs[6] = '{ka, r2, 7'd64,  1'b1, hmac_model(ka, r2, 64),  1'b0, CACHED};
    vecs[7] = '{kb, r3, 7'd111, 1'b0, hmac_model(kb, r3, 111), 1'b0, FULL};
    vecs[8] = '{kb, r3, 7'd112, 1'b0, vecs[7].exp_out, 1'b1, ERRLAT};

    reset = 1'b0; start = 1'b0; key_reuse = 1'b0; msg_len = '0; key = '0; msg = '0;
    #1;
    chk_w("reset_out", out, '0);
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_done", int'(done), 0);
    chk_i("reset_err", int'(err), 0);
    chk_i("reset_cache_valid", int'(cache_valid), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cv_m = 1'b0;

    for (int i = 0; i < 9; i++) begin
      exp_cv_mid = (int'(vecs[i].len) > int'(MAXB)) ? cv_m : (vecs[i].reuse && cv_m);
      do_run(vecs[i].k, vecs[i].m, vecs[i].len, vecs[i].reuse, lat, cv_mid, busy_ok, pulse_ok);
      chk_w($sformatf("v%0d_out", i), out, vecs[i].exp_out);
      chk_i($sformatf("v%0d_err", i), int'(err), int'(vecs[i].exp_err));
      chk_i($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk_i($sformatf("v%0d_cache_mid", i), int'(cv_mid), int'(exp_cv_mid));
      if (!vecs[i].exp_err) cv_m = 1'b1;
      chk_i($sformatf("v%0d_cache_after", i), int'(cache_valid), int'(cv_m));
      chk_i($sformatf("v%0d_busy", i), int'(busy_ok), 1);
      chk_i($sformatf("v%0d_done_pulse", i), int'(pulse_ok), 1);
    end

    // start pulses while busy carry bogus operands and must be ignored
    @(negedge clk);
    key = k2; msg = m2; msg_len = 7'd28; key_reuse = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (lat == 10 || lat == 200) begin
        start = 1'b1; msg_len = 7'd112; key_reuse = 1'b1; key = '0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk_i("ignore_latency", lat, FULL);
    chk_w("ignore_out", out, TC2_OUT);
    chk_i("ignore_err", int'(err), 0);

    // start held through DONE: back-to-back cached runs with no IDLE cycle
    @(negedge clk);
    key = k2; msg = m2; msg_len = 7'd28; key_reuse = 1'b1; start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk_i("b2b_first_latency", lat, CACHED);
    @(negedge clk);
    start = 1'b0;
    chk_i("b2b_done_pulse", int'(done), 0);
    chk_i("b2b_no_idle_busy", int'(busy), 1);
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk_i("b2b_second_latency", lat, CACHED);
    chk_w("b2b_out", out, TC2_OUT);
    @(negedge clk);
    chk_i("b2b_second_pulse", int'(done), 0);

    // asynchronous reset during MSG_R, then a reuse request must recompute midstates
    @(negedge clk);
    key = k1; msg = m1; msg_len = 7'd8; key_reuse = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 200 && !done) begin
      @(negedge clk);
      lat++;
    end
    #1 reset = 1'b0;
    #1;
    chk_w("arst_out", out, '0);
    chk_i("arst_busy", int'(busy), 0);
    chk_i("arst_done", int'(done), 0);
    chk_i("arst_err", int'(err), 0);
    chk_i("arst_cache_valid", int'(cache_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    do_run(k2, m2, 7'd28, 1'b1, lat, cv_mid, busy_ok, pulse_ok);
    chk_i("post_arst_latency", lat, FULL);
    chk_w("post_arst_out", out, TC2_OUT);
    chk_i("post_arst_cache_valid", int'(cache_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hmac_sha512_cached.md
Name: hmac_sha512_cached

Overview:
Single-block HMAC-SHA512 engine with a start/done handshake, replacing reset-driven one-shot sequencing. Message length is set at run time (0..MSG_MAX_BYTES bytes) instead of a two-way mode bit. Inner and outer key midstates are cached, so PBKDF2 iterations that reuse a key take 2 compressions instead of 4. It sits between the PBKDF2 iteration controller and one shared sha512_chunk instance.

Parameters:
MSG_MAX_BYTES, 111, largest accepted message in bytes; legal range 1..111, the single-block limit with padding.
LEN_W, 7, width of msg_len.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
start  input  1  request a run; sampled only in IDLE or DONE
key_reuse  input  1  sampled with start; 1 = use cached midstates if cache_valid
msg_len  input  LEN_W  message length in bytes, sampled with start
key  input  1024  key, zero padded, byte 0 at bits [1023:1016]
msg  input  8*MSG_MAX_BYTES  message, byte 0 at MSB; bytes at or beyond msg_len are don't-care
busy  output  1  run in progress
done  output  1  one-cycle pulse; out and err valid
err  output  1  msg_len > MSG_MAX_BYTES on the last run
cache_valid  output  1  cached ipad/opad midstates are usable
out  output  512  HMAC result, held until next accepted start

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; busy=0, done=0, err=0, cache_valid=0, out=0; sha512_chunk held in reset.
- Inputs are captured into internal registers on the accepted start; the host may change them afterwards.
- A start seen while busy=1 is ignored.
- States: IDLE, DECIDE, IPAD_0, IPAD_R, OPAD_0, OPAD_R, MSG_0, MSG_R, SUM_0, SUM_R, DONE.
- Accepted start -> DECIDE; busy=1 from this cycle until the cycle before done.
- DECIDE:
  - captured msg_len > MSG_MAX_BYTES -> DONE with err=1; out is unchanged and cache is untouched.
  - else key_reuse && cache_valid -> MSG_0.
  - else cache_valid<=0 -> IPAD_0.
- Every X_0 state loads chunk and iH and holds sha512_chunk reset low for one cycle.
- Every X_R state releases sha512_chunk reset and waits for its done. On done, oH is captured and the next X_0 follows.
- IPAD: chunk = key ^ {128{8'h36}}; iH = SHA-512 IV. Result goes to mid_i.
- OPAD: chunk = key ^ {128{8'h5c}}; iH = IV. Result goes to mid_o. Set cache_valid=1 when OPAD_R completes.
- MSG: iH = mid_i. chunk layout by byte index b:
  - b < L (captured msg_len): msg byte b.
  - b = L: 8'h80.
  - L < b < 112: 0.
  - bytes 112..127: 128-bit big-endian bit count (128+L)*8.
- SUM: iH = mid_o. chunk = inner hash in bytes 0..63, then 8'h80, then zeros, then length 0x600 in bytes 112..127.
- SUM_R done -> out <= oH; go to DONE.
- DONE: done=1 for exactly one cycle; busy=0; err as decided.
  - Next state is IDLE, or DECIDE if start is high in that same cycle (back-to-back runs allowed).
- Latency: with C = sha512_chunk cycles from reset release to done, start-to-done is 4*(C+2)+2 cycles for a full run, 2*(C+2)+2 cached, and 2 for an err run.
- Reset mid-run aborts the run and clears everything, including the cache.
- msg_len=0 is legal: byte 0 = 8'h80, length field 0x400.
- msg_len=MSG_MAX_BYTES=111: byte 111 = 8'h80, immediately followed by the length field.
- The cache is keyed only by the host's key_reuse bit. The block does not compare keys; asserting key_reuse with a new key gives a wrong result by design.

Test Plan:
- RFC4231 TC1: key=20x0b (zero padded), msg="Hi There", L=8, key_reuse=0 -> out=87aa7cdea5ef619d4ff0b4241a1d6cb02379f4e2ce4ec2787ad0b30545e17cdedaa833b7d6b8a702038b274eaea3f4e4be9d914eeb61f1702e696c203a126854; cache_valid=1; latency 4*(C+2)+2.
- RFC4231 TC2: key="Jefe", msg="what do ya want for nothing?", L=28 -> out=164b7a7bfcf819e2e395fbe73b56e0a387bd64222e831fd610270cd7ea2505549758bf75c05a994a6d034f65f8f0e6fdcaeab1a34d4a6b4b636e070a38bce737.
- Cache reuse: repeat TC2 with key_reuse=1 -> identical out, latency 2*(C+2)+2.
  - Then send TC1's key with key_reuse=0 -> TC1 result; cache_valid drops to 0 during IPAD/OPAD.
- Length sweep: L=0, 36, 64, 111 with random key/msg, garbage past L -> match software HMAC-SHA512; L=112 -> done after 2 cycles, err=1, out unchanged.
- Handshake: start pulses while busy are ignored. start held high through DONE -> back-to-back run with no IDLE cycle; done is a 1-cycle pulse each run.
- Async reset asserted mid-MSG_R -> all outputs 0 immediately; a following key_reuse=1 run performs all 4 compressions.
